// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM encoding and per-stage control bundle.
package pipeline_stall_controller_pkg;

    localparam int unsigned STALL_FSM_W = 2;

    typedef enum logic [STALL_FSM_W-1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_ERROR    = 2'd3
    } stall_state_e;

    typedef struct packed {
        logic pc_freeze;
        logic if_id_freeze;
        logic id_exe_bubble;
        logic if_id_flush;
        logic back_freeze;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_IDLE       = 5'b00000;
    localparam stage_ctrl_t CTRL_FREEZE_ALL = 5'b11001;
    localparam stage_ctrl_t CTRL_FLUSH      = 5'b00110;
    localparam stage_ctrl_t CTRL_HAZARD     = 5'b11100;

    function automatic logic mem_stall_of(input logic req, input logic ready);
        return req & ~ready;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module pipeline_stall_controller_sat_counter
    import pipeline_stall_controller_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: merges hazard, branch and memory-wait requests into
// same-cycle per-stage freeze/flush/bubble controls, with a memory timeout and perf counters.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned TO_W         = 8,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             id_exe_bubble,
    output logic             if_id_flush,
    output logic             back_freeze,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int unsigned FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    stall_state_e    state;
    logic [TO_W-1:0] wait_cnt;
    logic [FL_W-1:0] flush_left;
    logic            mem_stall;
    logic            accept_branch;
    stage_ctrl_t     ctrl;

    // Same-cycle control decode; priority ERROR > mem_stall > branch > hazard.
    always_comb begin
        ctrl          = CTRL_IDLE;
        accept_branch = 1'b0;
        mem_stall     = mem_stall_of(mem_req, mem_ready);
        case (state)
            ST_ERROR: ctrl = CTRL_FREEZE_ALL;
            ST_FLUSH: ctrl = mem_stall ? CTRL_FREEZE_ALL : CTRL_FLUSH;
            default: begin
                if (mem_stall) begin
                    ctrl = CTRL_FREEZE_ALL;
                end else if (branch_taken) begin
                    ctrl          = CTRL_FLUSH;
                    accept_branch = 1'b1;
                end else if (hazard_detected) begin
                    ctrl = CTRL_HAZARD;
                end
            end
        endcase
        // Reset must silence the controls immediately, even with requests pending.
        if (!rst_n) begin
            ctrl          = CTRL_IDLE;
            accept_branch = 1'b0;
        end
    end

    // State, memory-wait counter and flush counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            wait_cnt   <= '0;
            flush_left <= '0;
        end else begin
            case (state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (mem_stall) begin
                        if (state == ST_RUN) begin
                            state    <= ST_MEM_WAIT;
                            wait_cnt <= TO_W'(1);
                        end else if (wait_cnt == TO_W'(TIMEOUT)) begin
                            state <= ST_ERROR;
                        end else begin
                            wait_cnt <= wait_cnt + TO_W'(1);
                        end
                    end else begin
                        wait_cnt <= '0;
                        if (branch_taken && (FLUSH_CYCLES > 1)) begin
                            state      <= ST_FLUSH;
                            flush_left <= FL_W'(FLUSH_CYCLES - 1);
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!mem_stall) begin
                        flush_left <= flush_left - FL_W'(1);
                        if (flush_left == FL_W'(1)) begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_ERROR: state <= ST_ERROR;
            endcase
        end
    end

    assign pc_freeze     = ctrl.pc_freeze;
    assign if_id_freeze  = ctrl.if_id_freeze;
    assign id_exe_bubble = ctrl.id_exe_bubble;
    assign if_id_flush   = ctrl.if_id_flush;
    assign back_freeze   = ctrl.back_freeze;
    assign timeout_err   = (state == ST_ERROR);

    pipeline_stall_controller_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl.pc_freeze),
        .count (stall_cycles)
    );

    pipeline_stall_controller_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept_branch),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: two parameterisations driven in lockstep against a
// behavioural model, plus a directed vector table and hand-written corner sequences.
module tb_pipeline_stall_controller;

    localparam int unsigned A_FC  = 2;
    localparam int unsigned A_TO  = 4;
    localparam int unsigned A_TOW = 8;
    localparam int unsigned A_CW  = 4;
    localparam int unsigned B_FC  = 1;
    localparam int unsigned B_TO  = 6;
    localparam int unsigned B_TOW = 3;
    localparam int unsigned B_CW  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, hazard_detected, branch_taken, mem_req, mem_ready;

    logic a_pc, a_ifid, a_bub, a_fl, a_back, a_err;
    logic [A_CW-1:0] a_stall, a_flush;
    logic b_pc, b_ifid, b_bub, b_fl, b_back, b_err;
    logic [B_CW-1:0] b_stall, b_flush;

    pipeline_stall_controller #(.FLUSH_CYCLES(A_FC), .TIMEOUT(A_TO), .TO_W(A_TOW), .CNT_W(A_CW)) dut_a (
        .clk(clk), .rst_n(rst_n), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_freeze(a_pc), .if_id_freeze(a_ifid),
        .id_exe_bubble(a_bub), .if_id_flush(a_fl), .back_freeze(a_back), .timeout_err(a_err),
        .stall_cycles(a_stall), .flush_events(a_flush)
    );

    pipeline_stall_controller #(.FLUSH_CYCLES(B_FC), .TIMEOUT(B_TO), .TO_W(B_TOW), .CNT_W(B_CW)) dut_b (
        .clk(clk), .rst_n(rst_n), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_freeze(b_pc), .if_id_freeze(b_ifid),
        .id_exe_bubble(b_bub), .if_id_flush(b_fl), .back_freeze(b_back), .timeout_err(b_err),
        .stall_cycles(b_stall), .flush_events(b_flush)
    );

    wire [5:0] a_obs = {a_pc, a_ifid, a_bub, a_fl, a_back, a_err};
    wire [5:0] b_obs = {b_pc, b_ifid, b_bub, b_fl, b_back, b_err};

    int n_checks = 0;
    int n_errors = 0;

    // Model: error flag, consecutive stalled cycles outside a flush, remaining flush cycles.
    int     m_fc[2];
    int     m_to[2];
    longint m_max[2];
    bit     m_err[2];
    int     m_run[2];
    int     m_frem[2];
    longint m_stall[2];
    longint m_flush[2];

    typedef struct {
        logic r, h, b, q, y;
        logic [5:0] exp;
        int stl;
        int fls;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic h, logic b, logic q, logic y,
                                logic [5:0] e, int s, int f);
        vec_t v;
        v.r = r; v.h = h; v.b = b; v.q = q; v.y = y; v.exp = e; v.stl = s; v.fls = f;
        return v;
    endfunction

    // {pc_freeze, if_id_freeze, id_exe_bubble, if_id_flush, back_freeze, timeout_err}
    function automatic logic [5:0] exp_out(int i);
        logic stall;
        stall = mem_req & ~mem_ready;
        if (!rst_n) return 6'b000000;
        if (m_err[i]) return 6'b110011;
        if (m_frem[i] > 0) return stall ? 6'b110010 : 6'b001100;
        if (stall) return 6'b110010;
        if (branch_taken) return 6'b001100;
        if (hazard_detected) return 6'b111000;
        return 6'b000000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_err[i] = 1'b0; m_run[i] = 0; m_frem[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end
    endtask

    task automatic model_clock(int i);
        logic [5:0] o;
        logic stall;
        o = exp_out(i);
        stall = mem_req & ~mem_ready;
        if (!rst_n) begin
            m_err[i] = 1'b0; m_run[i] = 0; m_frem[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
            return;
        end
        if (o[5] && m_stall[i] < m_max[i]) m_stall[i]++;
        if (m_err[i]) return;
        if (m_frem[i] > 0) begin
            if (!stall) m_frem[i]--;
        end else if (stall) begin
            m_run[i]++;
            if (m_run[i] > m_to[i]) m_err[i] = 1'b1;
        end else begin
            m_run[i] = 0;
            if (branch_taken) begin
                if (m_flush[i] < m_max[i]) m_flush[i]++;
                m_frem[i] = m_fc[i] - 1;
            end
        end
    endtask

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, "_a_ctrl"}, a_obs, exp_out(0));
        check({tag, "_b_ctrl"}, b_obs, exp_out(1));
        check({tag, "_a_stall"}, a_stall, m_stall[0]);
        check({tag, "_a_flush"}, a_flush, m_flush[0]);
        check({tag, "_b_stall"}, b_stall, m_stall[1]);
        check({tag, "_b_flush"}, b_flush, m_flush[1]);
    endtask

    task automatic phase_pre(logic r, logic h, logic b, logic q, logic y);
        @(negedge clk);
        rst_n = r; hazard_detected = h; branch_taken = b; mem_req = q; mem_ready = y;
        if (!r) model_reset();
        #1;
        check_all("pre");
    endtask

    task automatic phase_post();
        @(posedge clk);
        #1;
        model_clock(0);
        model_clock(1);
        check("post_a_stall", a_stall, m_stall[0]);
        check("post_a_flush", a_flush, m_flush[0]);
        check("post_b_stall", b_stall, m_stall[1]);
        check("post_b_flush", b_flush, m_flush[1]);
    endtask

    task automatic step(logic r, logic h, logic b, logic q, logic y);
        phase_pre(r, h, b, q, y);
        phase_post();
    endtask

    initial begin
        int burst;
        logic q, y;
        m_fc[0] = A_FC; m_to[0] = A_TO; m_max[0] = (64'd1 << A_CW) - 1;
        m_fc[1] = B_FC; m_to[1] = B_TO; m_max[1] = (64'd1 << B_CW) - 1;
        rst_n = 1'b0; hazard_detected = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        model_reset();
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0);

        // Directed table, expectations for dut_a (FLUSH_CYCLES=2, TIMEOUT=4, CNT_W=4).
        tbl.push_back(mk(1, 1, 0, 0, 0, 6'b111000, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 6'b111000, 2, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 6'b001100, 2, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 6'b001100, 2, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 6'b000000, 2, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 6'b110010, 3, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 6'b110010, 4, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 6'b110010, 5, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 6'b110010, 6, 1));
        tbl.push_back(mk(1, 0, 1, 1, 1, 6'b001100, 6, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 6'b110010, 7, 2));
        tbl.push_back(mk(1, 1, 0, 0, 0, 6'b001100, 7, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 6'b110010, 8, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 6'b110010, 9, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 6'b110010, 10, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 6'b110010, 11, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 6'b110010, 12, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 6'b110011, 13, 2));
        tbl.push_back(mk(1, 1, 1, 0, 0, 6'b110011, 14, 2));
        tbl.push_back(mk(1, 0, 0, 1, 1, 6'b110011, 15, 2));
        tbl.push_back(mk(1, 1, 0, 0, 0, 6'b110011, 15, 2));
        tbl.push_back(mk(0, 1, 0, 1, 0, 6'b000000, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 6'b001100, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 6'b001100, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 6'b000000, 0, 1));
        foreach (tbl[i]) begin
            phase_pre(tbl[i].r, tbl[i].h, tbl[i].b, tbl[i].q, tbl[i].y);
            check($sformatf("tbl%0d_ctrl", i), a_obs, tbl[i].exp);
            phase_post();
            check($sformatf("tbl%0d_stall", i), a_stall, tbl[i].stl);
            check($sformatf("tbl%0d_flush", i), a_flush, tbl[i].fls);
        end

        // Async reset in the middle of a long memory wait (dut_b wait count reaches 5).
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 1, 0);
        check("midwait_b_stall", b_stall, 5);
        @(negedge clk);
        #2;
        rst_n = 1'b0; hazard_detected = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        check("async_rst_a_zero", a_obs, 0);
        check("async_rst_b_zero", b_obs, 0);
        step(0, 1, 0, 1, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 1, 0);
        check("after_rst_a_noerr", a_err, 0);
        step(1, 0, 0, 1, 0);
        check("after_rst_a_err", a_err, 1);

        // Hazard held 20 cycles: 4-bit counter saturates at 15.
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(1, 1, 0, 0, 0);
        check("sat_a_stall", a_stall, 15);
        check("sat_b_stall", b_stall, 20);

        // Randomised traffic with occasional long memory stalls and resets.
        burst = 0;
        for (int k = 0; k < 3000; k++) begin
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(3, 10);
            if (burst > 0) begin
                q = 1'b1; y = 1'b0; burst--;
            end else begin
                q = 1'($urandom_range(0, 1));
                y = ($urandom_range(0, 2) != 0);
            end
            step(($urandom_range(0, 47) != 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) == 0), q, y);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
